load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the instruction decoder.
- Consumes decoded mem_read/mem_write, funct3, the ALU-computed effective address and rs2 store data.
- Performs one load or store per request over a valid/ready data-memory bus, with byte-lane strobes, load sign/zero extension and a bus timeout.
- Returns load data or an error to the writeback stage through a single-cycle response pulse.

---
 rtl/load_store_unit.sv | 122 ++++++++++++
 tb/tb_load_store_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: one load/store per request over a valid/ready bus; LSU_MISALIGN_TRAP_EN enables misaligned-access errors.
module load_store_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output logic              resp_valid,
  output logic [31:0]       load_data,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] f3;
  logic [1:0] lane;
  logic bad, misalign, expired;
  logic [3:0] strb;
  logic [31:0] wdata, byte_sh, half_sh, ext;
  always_comb begin
    bad = (mem_read && mem_write) ||
          (mem_read ? (funct3 == 3'b011 || funct3[2:1] == 2'b11) : (funct3 > 3'b010));
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    strb = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
           funct3[1:0] == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    wdata = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
            funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
    byte_sh = bus_rdata >> {lane, 3'b000};
    half_sh = bus_rdata >> {lane[1], 4'b0000};
    ext = f3[1:0] == 2'b00 ? {{24{~f3[2] & byte_sh[7]}}, byte_sh[7:0]} :
          f3[1:0] == 2'b01 ? {{16{~f3[2] & half_sh[15]}}, half_sh[15:0]} : bus_rdata;
    expired = cnt >= CW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      bus_valid  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wstrb  <= 4'b0;
      bus_wdata  <= 32'b0;
      resp_valid <= 1'b0;
      load_data  <= 32'b0;
      err        <= 1'b0;
      cnt        <= '0;
      f3         <= 3'b0;
      lane       <= 2'b0;
    end else begin
      resp_valid <= 1'b0;
      err        <= 1'b0;
      load_data  <= 32'b0;
      case (state)
        IDLE: if (req_valid && (mem_read || mem_write)) begin
          req_ready <= 1'b0;
          if (bad || misalign) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            err        <= 1'b1;
          end else begin
            state     <= REQ;
            bus_valid <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_wstrb <= mem_write ? strb : 4'b0;
            bus_wdata <= mem_write ? wdata : 32'b0;
            f3        <= funct3;
            lane      <= addr[1:0];
            cnt       <= '0;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (bus_ready) begin
            bus_valid  <= 1'b0;
            state      <= bus_we ? RESP : WAIT;
            resp_valid <= bus_we;
          end else if (expired) begin
            bus_valid  <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            err        <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus_rvalid || expired) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            err        <= ~bus_rvalid;
            load_data  <= bus_rvalid ? ext : 32'b0;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit with TIMEOUT=4.
module tb_load_store_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 0, req_ready, mem_read = 0, mem_write = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, store_data = 0;
  logic bus_valid, bus_ready = 1, bus_we, bus_rvalid = 0;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = 0, load_data;
  logic [3:0] bus_wstrb;
  logic resp_valid, err;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .addr(addr),
    .store_data(store_data), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .resp_valid(resp_valid),
    .load_data(load_data), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns at t+1.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f, input logic [31:0] a, input logic [31:0] sd);
    req_valid = 1; mem_read = rd; mem_write = wr; funct3 = f; addr = a; store_data = sd;
    tick;
    req_valid = 0; mem_read = 0; mem_write = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    tick; tick;
    rst = 0;
    n_cmp++;
    if ({req_ready, bus_valid, bus_we, bus_wstrb, resp_valid, err} !== 9'b1_0_0_0000_0_0) begin
      n_err++; $display("FAIL reset_ctl got %b want 100000000", {req_ready, bus_valid, bus_we, bus_wstrb, resp_valid, err});
    end
    n_cmp++;
    if ({bus_addr, bus_wdata, load_data} !== 96'h0) begin
      n_err++; $display("FAIL reset_data got %h want 0", {bus_addr, bus_wdata, load_data});
    end
  endtask

  task automatic test_sw;
    bus_ready = 1;
    issue(0, 1, 3'b010, 32'h104, 32'hDEADBEEF);
    n_cmp++;
    if ({bus_valid, bus_we, bus_wstrb} !== 6'b1_1_1111) begin
      n_err++; $display("FAIL sw_bus got %b want 111111", {bus_valid, bus_we, bus_wstrb});
    end
    n_cmp++;
    if ({bus_addr, bus_wdata} !== {32'h104, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL sw_addr_data got %h want 00000104deadbeef", {bus_addr, bus_wdata});
    end
    tick;
    n_cmp++;
    if ({resp_valid, err, bus_valid} !== 3'b100 || load_data !== 32'h0) begin
      n_err++; $display("FAIL sw_resp got %b/%h want 100/0", {resp_valid, err, bus_valid}, load_data);
    end
    tick;
    n_cmp++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      n_err++; $display("FAIL sw_idle got %b want 01", {resp_valid, req_ready});
    end
  endtask

  task automatic test_sb;
    issue(0, 1, 3'b000, 32'h203, 32'h000000A5);
    n_cmp++;
    if ({bus_valid, bus_wstrb, bus_addr, bus_wdata} !== {1'b1, 4'b1000, 32'h200, 32'hA5A5A5A5}) begin
      n_err++; $display("FAIL sb_bus got %b %b %h %h want 1 1000 00000200 a5a5a5a5", bus_valid, bus_wstrb, bus_addr, bus_wdata);
    end
    tick;
    n_cmp++;
    if ({resp_valid, err} !== 2'b10) begin
      n_err++; $display("FAIL sb_resp got %b want 10", {resp_valid, err});
    end
    tick;
  endtask

  task automatic test_lb;
    logic [2:0] fs [2] = '{3'b000, 3'b100};
    logic [31:0] exp [2] = '{32'hFFFFFFF0, 32'h000000F0};
    for (int i = 0; i < 2; i++) begin
      issue(1, 0, fs[i], 32'h302, 32'h0);
      n_cmp++;
      if ({bus_valid, bus_we, bus_wstrb, bus_addr} !== {1'b1, 1'b0, 4'b0000, 32'h300}) begin
        n_err++; $display("FAIL lb_bus%0d got %b %b %b %h want 1 0 0000 00000300", i, bus_valid, bus_we, bus_wstrb, bus_addr);
      end
      tick;
      bus_rvalid = 1; bus_rdata = 32'h12F03456;
      tick;
      bus_rvalid = 0;
      n_cmp++;
      if ({resp_valid, err} !== 2'b10 || load_data !== exp[i]) begin
        n_err++; $display("FAIL lb_data%0d got %b %h want 10 %h", i, {resp_valid, err}, load_data, exp[i]);
      end
      tick;
    end
  endtask

  task automatic test_lh_stall;
    bus_ready = 0;
    issue(1, 0, 3'b001, 32'h402, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus_ready = 1;
      n_cmp++;
      if ({bus_valid, bus_we, bus_wstrb, bus_addr, resp_valid} !== {1'b1, 1'b0, 4'b0000, 32'h400, 1'b0}) begin
        n_err++; $display("FAIL lh_hold%0d got %b %b %b %h %b want 1 0 0000 00000400 0", i, bus_valid, bus_we, bus_wstrb, bus_addr, resp_valid);
      end
      tick;
    end
    n_cmp++;
    if (bus_valid !== 1'b0) begin
      n_err++; $display("FAIL lh_drop got %b want 0", bus_valid);
    end
    bus_rvalid = 1; bus_rdata = 32'h80010000;
    tick;
    bus_rvalid = 0;
    n_cmp++;
    if ({resp_valid, err} !== 2'b10 || load_data !== 32'hFFFF8001) begin
      n_err++; $display("FAIL lh_data got %b %h want 10 ffff8001", {resp_valid, err}, load_data);
    end
    tick;
    issue(1, 0, 3'b101, 32'h402, 32'h0);
    tick;
    bus_rvalid = 1;
    tick;
    bus_rvalid = 0;
    n_cmp++;
    if ({resp_valid, err} !== 2'b10 || load_data !== 32'h00008001) begin
      n_err++; $display("FAIL lhu_data got %b %h want 10 00008001", {resp_valid, err}, load_data);
    end
    tick;
  endtask

  task automatic test_timeout;
    bus_ready = 0;
    issue(1, 0, 3'b010, 32'h500, 32'h0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({bus_valid, resp_valid} !== 2'b10) begin
        n_err++; $display("FAIL to_wait%0d got %b want 10", i, {bus_valid, resp_valid});
      end
      tick;
    end
    n_cmp++;
    if ({resp_valid, err, bus_valid} !== 3'b110 || load_data !== 32'h0) begin
      n_err++; $display("FAIL to_resp got %b %h want 110 0", {resp_valid, err, bus_valid}, load_data);
    end
    tick;
    bus_ready = 1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL to_ready got %b want 1", req_ready);
    end
    issue(0, 1, 3'b001, 32'h602, 32'h00001234);
    n_cmp++;
    if ({bus_valid, bus_wstrb, bus_wdata} !== {1'b1, 4'b1100, 32'h12341234}) begin
      n_err++; $display("FAIL to_next got %b %b %h want 1 1100 12341234", bus_valid, bus_wstrb, bus_wdata);
    end
    tick;
    n_cmp++;
    if ({resp_valid, err} !== 2'b10) begin
      n_err++; $display("FAIL to_next_resp got %b want 10", {resp_valid, err});
    end
    tick;
  endtask

  task automatic test_errors;
    logic rds [3] = '{1'b1, 1'b1, 1'b0};
    logic wrs [3] = '{1'b1, 1'b0, 1'b1};
    logic [2:0] fs [3] = '{3'b010, 3'b011, 3'b100};
    for (int i = 0; i < 3; i++) begin
      issue(rds[i], wrs[i], fs[i], 32'h700, 32'h0);
      n_cmp++;
      if ({resp_valid, err, bus_valid} !== 3'b110) begin
        n_err++; $display("FAIL err_case%0d got %b want 110", i, {resp_valid, err, bus_valid});
      end
      tick;
    end
  endtask

  task automatic test_ignore;
    bus_rvalid = 1;
    issue(0, 0, 3'b010, 32'h800, 32'h0);
    bus_rvalid = 0;
    n_cmp++;
    if ({req_ready, bus_valid, resp_valid} !== 3'b100) begin
      n_err++; $display("FAIL ignore got %b want 100", {req_ready, bus_valid, resp_valid});
    end
  endtask

  task automatic test_misalign;
    issue(1, 0, 3'b010, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++;
    if ({resp_valid, err, bus_valid} !== 3'b110) begin
      n_err++; $display("FAIL mis_trap got %b want 110", {resp_valid, err, bus_valid});
    end
    tick;
`else
    n_cmp++;
    if ({bus_valid, bus_wstrb, bus_addr} !== {1'b1, 4'b0000, 32'h100}) begin
      n_err++; $display("FAIL mis_bus got %b %b %h want 1 0000 00000100", bus_valid, bus_wstrb, bus_addr);
    end
    tick;
    bus_rvalid = 1; bus_rdata = 32'hCAFEF00D;
    tick;
    bus_rvalid = 0;
    n_cmp++;
    if ({resp_valid, err} !== 2'b10 || load_data !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL mis_data got %b %h want 10 cafef00d", {resp_valid, err}, load_data);
    end
    tick;
`endif
  endtask

  task automatic test_reset_mid;
    bus_ready = 0;
    issue(1, 0, 3'b010, 32'h900, 32'h0);
    tick;
    rst = 1;
    #1;
    n_cmp++;
    if ({req_ready, bus_valid, resp_valid, err} !== 4'b1000) begin
      n_err++; $display("FAIL rst_mid got %b want 1000", {req_ready, bus_valid, resp_valid, err});
    end
    tick;
    rst = 0;
    bus_ready = 1;
    tick;
    n_cmp++;
    if ({req_ready, bus_valid, resp_valid} !== 3'b100) begin
      n_err++; $display("FAIL rst_after got %b want 100", {req_ready, bus_valid, resp_valid});
    end
  endtask

  initial begin
    test_reset;
    test_sw;
    test_sb;
    test_lb;
    test_lh_stall;
    test_timeout;
    test_errors;
    test_ignore;
    test_misalign;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
